// File: rtl/cal_abs_angle_if.sv
// Sample/result bundle for the polar converter: one complex sample in, magnitude and phase out.
`timescale 1ns/1ps
interface cal_abs_angle_if;
    logic signed [7:0]  real_i;
    logic signed [7:0]  imag_i;
    logic               val_i;
    logic        [7:0]  abs_o;
    logic signed [15:0] angle_o;
    logic               val_o;

    modport master (output real_i, imag_i, val_i, input abs_o, angle_o, val_o);
    modport slave  (input real_i, imag_i, val_i, output abs_o, angle_o, val_o);
endinterface

// File: rtl/cal_abs_angle.sv
// Streaming polar converter: floor(sqrt(re^2+im^2)) and atan2(im,re) in Q3.13 radians.
// Fixed 16-cycle pipeline, one sample per clock, valid bit shifted alongside the data.
`timescale 1ns/1ps
module cal_abs_angle (
    input  logic           clk,
    input  logic           rst,
    cal_abs_angle_if.slave bus
);
    localparam int DW      = 8;
    localparam int AW      = 16;
    localparam int AFRAC   = 13;
    localparam int LATENCY = 16;

    localparam int RW    = 14;
    localparam int XYW   = 30;
    localparam int ZW    = 24;
    localparam int ZFRAC = 20;
    localparam int CSTG  = 8;
    localparam int NPAD  = LATENCY - 2 - CSTG - 1;

    localparam logic signed [ZW-1:0] PI_Z      = 24'sd3294199;
    localparam logic signed [ZW-1:0] ZRND      = 24'sd64;
    localparam logic signed [ZW-1:0] ANG_MAX_Z = 24'sd25736;
    localparam logic signed [ZW-1:0] ATAN [16] = '{
        24'sd823550, 24'sd486170, 24'sd256879, 24'sd130396,
        24'sd65451,  24'sd32757,  24'sd16383,  24'sd8192,
        24'sd4096,   24'sd2048,   24'sd1024,   24'sd512,
        24'sd256,    24'sd128,    24'sd64,     24'sd32
    };

    typedef struct packed {
        logic signed [XYW-1:0] x;
        logic signed [XYW-1:0] y;
        logic signed [ZW-1:0]  z;
    } cvec_t;

    // Non-restoring square-root remainder update for one result bit.
    function automatic logic signed [RW-1:0] sqrt_rem(input logic signed [RW-1:0] r,
                                                      input logic [7:0] q,
                                                      input logic [1:0] d);
        logic signed [RW-1:0] sh, t1, t3;
        sh = (r <<< 2) + $signed({{(RW-2){1'b0}}, d});
        t1 = $signed({{(RW-10){1'b0}}, q, 2'b01});
        t3 = $signed({{(RW-10){1'b0}}, q, 2'b11});
        return r[RW-1] ? (sh + t3) : (sh - t1);
    endfunction

    // Vectoring step; y == 0 means the vector is already on the axis, so hold.
    function automatic cvec_t cordic_iter(input cvec_t v, input int i,
                                          input logic signed [ZW-1:0] a);
        cvec_t r;
        r = v;
        if (v.y > 0) begin
            r.x = v.x + (v.y >>> i);
            r.y = v.y - (v.x >>> i);
            r.z = v.z + a;
        end else if (v.y < 0) begin
            r.x = v.x - (v.y >>> i);
            r.y = v.y + (v.x >>> i);
            r.z = v.z - a;
        end
        return r;
    endfunction

    function automatic logic signed [AW-1:0] round_sat_angle(input logic signed [ZW-1:0] z);
        logic signed [ZW-1:0] r;
        r = (z + ZRND) >>> (ZFRAC - AFRAC);
        if (r > ANG_MAX_Z)
            r = ANG_MAX_Z;
        else if (r < -ANG_MAX_Z)
            r = -ANG_MAX_Z;
        return AW'(r);
    endfunction

    logic signed [DW-1:0] re_p0_q, im_p0_q;
    logic        [15:0]   sum_p1_q, sum_d;
    cvec_t                c_q [0:CSTG];
    cvec_t                c_d [0:CSTG];
    logic        [15:0]   rad_q  [1:7];
    logic        [15:0]   rad_d  [1:7];
    logic signed [RW-1:0] rem_q  [1:7];
    logic signed [RW-1:0] rem_d  [1:7];
    logic        [7:0]    root_q [1:8];
    logic        [7:0]    root_d [1:8];
    logic        [7:0]    abs_pad_q [0:NPAD-1];
    logic signed [AW-1:0] ang_pad_q [0:NPAD-1];
    logic        [7:0]    abs_q;
    logic signed [AW-1:0] angle_q;
    logic [LATENCY-1:0]   vld_q;

    always_comb begin
        logic signed [15:0]   re_x, im_x;
        logic signed [9:0]    re10, im10, x0, y0;
        logic signed [RW-1:0] rn;
        cvec_t                v;

        // p0 -> p1: squares and half-plane pre-rotation
        re_x  = $signed({{8{re_p0_q[DW-1]}}, re_p0_q});
        im_x  = $signed({{8{im_p0_q[DW-1]}}, im_p0_q});
        sum_d = re_x * re_x + im_x * im_x;

        re10 = $signed({{2{re_p0_q[DW-1]}}, re_p0_q});
        im10 = $signed({{2{im_p0_q[DW-1]}}, im_p0_q});
        c_d[0].z = '0;
        if (re10 < 0) begin
            x0 = -re10;
            y0 = -im10;
            c_d[0].z = (im10 < 0) ? -PI_Z : PI_Z;
        end else begin
            x0 = re10;
            y0 = im10;
        end
        c_d[0].x = $signed({x0, 20'd0});
        c_d[0].y = $signed({y0, 20'd0});

        // p1..p9: two CORDIC iterations per stage
        v = '0;
        for (int s = 0; s < CSTG; s++) begin
            v = cordic_iter(c_q[s], 2 * s, ATAN[2 * s]);
            v = cordic_iter(v, 2 * s + 1, ATAN[2 * s + 1]);
            c_d[s + 1] = v;
        end

        // p1..p9: one root bit per stage, radicand consumed two bits at a time
        rn        = sqrt_rem('0, '0, sum_p1_q[15:14]);
        rem_d[1]  = rn;
        root_d[1] = {7'd0, ~rn[RW-1]};
        rad_d[1]  = {sum_p1_q[13:0], 2'b00};
        for (int k = 2; k <= 7; k++) begin
            rn        = sqrt_rem(rem_q[k-1], root_q[k-1], rad_q[k-1][15:14]);
            rem_d[k]  = rn;
            root_d[k] = {root_q[k-1][6:0], ~rn[RW-1]};
            rad_d[k]  = {rad_q[k-1][13:0], 2'b00};
        end
        rn        = sqrt_rem(rem_q[7], root_q[7], rad_q[7][15:14]);
        root_d[8] = {root_q[7][6:0], ~rn[RW-1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            re_p0_q  <= '0;
            im_p0_q  <= '0;
            sum_p1_q <= '0;
            for (int i = 0; i <= CSTG; i++) c_q[i] <= '0;
            for (int i = 1; i <= 7; i++) begin
                rad_q[i] <= '0;
                rem_q[i] <= '0;
            end
            for (int i = 1; i <= 8; i++) root_q[i] <= '0;
            for (int i = 0; i < NPAD; i++) begin
                abs_pad_q[i] <= '0;
                ang_pad_q[i] <= '0;
            end
            abs_q   <= '0;
            angle_q <= '0;
            vld_q   <= '0;
        end else begin
            re_p0_q  <= bus.real_i;
            im_p0_q  <= bus.imag_i;
            sum_p1_q <= sum_d;
            for (int i = 0; i <= CSTG; i++) c_q[i] <= c_d[i];
            for (int i = 1; i <= 7; i++) begin
                rad_q[i] <= rad_d[i];
                rem_q[i] <= rem_d[i];
            end
            for (int i = 1; i <= 8; i++) root_q[i] <= root_d[i];
            // p10..p14: balance padding, angle rounded on entry
            abs_pad_q[0] <= root_q[8];
            ang_pad_q[0] <= round_sat_angle(c_q[CSTG].z);
            for (int i = 1; i < NPAD; i++) begin
                abs_pad_q[i] <= abs_pad_q[i-1];
                ang_pad_q[i] <= ang_pad_q[i-1];
            end
            // p15: output register
            abs_q   <= abs_pad_q[NPAD-1];
            angle_q <= ang_pad_q[NPAD-1];
            vld_q   <= {vld_q[LATENCY-2:0], bus.val_i};
        end
    end

    assign bus.abs_o   = abs_q;
    assign bus.angle_o = angle_q;
    assign bus.val_o   = vld_q[LATENCY-1];
endmodule

// File: tb/tb_cal_abs_angle.sv
// Directed and random stimulus for cal_abs_angle with an independent polar model.
`timescale 1ns/1ps
module tb_cal_abs_angle;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    logic signed [7:0] hre [0:1023];
    logic signed [7:0] him [0:1023];

    cal_abs_angle_if bus ();
    cal_abs_angle dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic int ref_abs(input int re, input int im);
        int s, r;
        s = re * re + im * im;
        r = 0;
        while ((r + 1) * (r + 1) <= s) r++;
        return r;
    endfunction

    function automatic int ref_ang(input int re, input int im);
        real a;
        a = $atan2(real'(im), real'(re)) * 8192.0;
        if (a >= 0.0) return $rtoi(a + 0.5);
        return -$rtoi(-a + 0.5);
    endfunction

    // Drives one valid sample and waits (bounded) for its result.
    task automatic send_one(input logic signed [7:0] re, input logic signed [7:0] im,
                            output logic [7:0] a, output logic signed [15:0] g,
                            output int lat);
        bus.real_i = re;
        bus.imag_i = im;
        bus.val_i  = 1'b1;
        lat = -1;
        a   = '0;
        g   = '0;
        for (int n = 1; n <= 24; n++) begin
            @(posedge clk); #1;
            if (n == 1) begin
                bus.val_i  = 1'b0;
                bus.real_i = '0;
                bus.imag_i = '0;
            end
            if (bus.val_o === 1'b1) begin
                lat = n;
                a   = bus.abs_o;
                g   = bus.angle_o;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bus.real_i = 8'sd3;
        bus.imag_i = 8'sd4;
        bus.val_i  = 1'b1;
        rst = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        n_vec++;
        if (bus.abs_o !== 8'd0) begin
            n_err++; $display("FAIL reset_abs: got %0d expected 0", bus.abs_o);
        end
        n_vec++;
        if (bus.angle_o !== 16'sd0) begin
            n_err++; $display("FAIL reset_angle: got %0d expected 0", bus.angle_o);
        end
        n_vec++;
        if (bus.val_o !== 1'b0) begin
            n_err++; $display("FAIL reset_val: got %b expected 0", bus.val_o);
        end
        bus.val_i = 1'b0;
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
    endtask

    task automatic test_corners();
        logic signed [7:0] vre [12] = '{3, 0, -128, 0, -128, 127, 0, 1, -3, 127, -128, -128};
        logic signed [7:0] vim [12] = '{4, 0, 0, -128, -128, 127, 5, 0, -4, -128, 1, -1};
        int exp_a [12] = '{5, 0, 128, 128, 181, 179, 5, 1, 5, 180, 128, 128};
        int exp_g [12] = '{7596, 0, 25736, -12868, -19302, 6434, 12868, 0, -18140, -6466,
                           25672, -25672};
        logic [7:0]         a;
        logic signed [15:0] g;
        int lat, diff;
        for (int i = 0; i < 12; i++) begin
            send_one(vre[i], vim[i], a, g, lat);
            n_vec++;
            if (lat !== 16) begin
                n_err++;
                $display("FAIL corner_latency (%0d,%0d): got %0d expected 16", vre[i], vim[i], lat);
            end
            n_vec++;
            if (a !== 8'(exp_a[i])) begin
                n_err++;
                $display("FAIL corner_abs (%0d,%0d): got %0d expected %0d", vre[i], vim[i], a, exp_a[i]);
            end
            diff = int'(g) - exp_g[i];
            n_vec++;
            if ($isunknown(g) || diff > 1 || diff < -1) begin
                n_err++;
                $display("FAIL corner_angle (%0d,%0d): got %0d expected %0d +/-1", vre[i], vim[i], g, exp_g[i]);
            end
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int idx, e_abs, e_ang, diff;
        bus.val_i = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        for (int cyc = 0; cyc < 1040; cyc++) begin
            if (cyc < 1024) begin
                hre[cyc]   = 8'($urandom_range(0, 255));
                him[cyc]   = 8'($urandom_range(0, 255));
                bus.real_i = hre[cyc];
                bus.imag_i = him[cyc];
                bus.val_i  = 1'b1;
            end else begin
                bus.val_i = 1'b0;
            end
            @(posedge clk); #1;
            idx = cyc - 15;
            n_vec++;
            if (idx < 0 || idx >= 1024) begin
                if (bus.val_o !== 1'b0) begin
                    n_err++; $display("FAIL b2b_val_idle cyc=%0d: got %b expected 0", cyc, bus.val_o);
                end
            end else begin
                if (bus.val_o !== 1'b1) begin
                    n_err++; $display("FAIL b2b_val sample=%0d: got %b expected 1", idx, bus.val_o);
                end
                e_abs = ref_abs(int'(hre[idx]), int'(him[idx]));
                e_ang = ref_ang(int'(hre[idx]), int'(him[idx]));
                n_vec++;
                if (bus.abs_o !== 8'(e_abs)) begin
                    n_err++;
                    $display("FAIL b2b_abs (%0d,%0d): got %0d expected %0d", hre[idx], him[idx], bus.abs_o, e_abs);
                end
                diff = int'(bus.angle_o) - e_ang;
                n_vec++;
                if ($isunknown(bus.angle_o) || diff > 1 || diff < -1) begin
                    n_err++;
                    $display("FAIL b2b_angle (%0d,%0d): got %0d expected %0d +/-1", hre[idx], him[idx], bus.angle_o, e_ang);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0]         a;
        logic signed [15:0] g;
        int lat;
        logic seen;
        bus.real_i = 8'sd3;
        bus.imag_i = 8'sd4;
        bus.val_i  = 1'b1;
        repeat (20) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        n_vec++;
        if (bus.abs_o !== 8'd0) begin
            n_err++; $display("FAIL midrst_abs: got %0d expected 0", bus.abs_o);
        end
        n_vec++;
        if (bus.angle_o !== 16'sd0) begin
            n_err++; $display("FAIL midrst_angle: got %0d expected 0", bus.angle_o);
        end
        n_vec++;
        if (bus.val_o !== 1'b0) begin
            n_err++; $display("FAIL midrst_val: got %b expected 0", bus.val_o);
        end
        bus.val_i = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if (bus.val_o !== 1'b0 || bus.abs_o !== 8'd0) begin
            n_err++; $display("FAIL midrst_hold: val=%b abs=%0d expected 0/0", bus.val_o, bus.abs_o);
        end
        #2 rst = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (bus.val_o !== 1'b0) seen = 1'b1;
        end
        n_vec++;
        if (seen !== 1'b0) begin
            n_err++; $display("FAIL midrst_flush: got val_o activity %b expected 0", seen);
        end
        send_one(8'sd5, 8'sd0, a, g, lat);
        n_vec++;
        if (lat !== 16) begin
            n_err++; $display("FAIL midrst_latency: got %0d expected 16", lat);
        end
        n_vec++;
        if (a !== 8'd5 || g > 16'sd1 || g < -16'sd1) begin
            n_err++; $display("FAIL midrst_result: abs=%0d angle=%0d expected 5/0", a, g);
        end
    endtask

    initial begin
        bus.real_i = '0;
        bus.imag_i = '0;
        bus.val_i  = 1'b0;
        test_reset();
        test_corners();
        test_back_to_back();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
